// File: rtl/loader_pkg.sv
// Shared constants for the instruction-memory byte-stream loader.
package loader_pkg;

    localparam int DEPTH_WORDS_DEF = 64;
    localparam int HDR_W           = 16;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR0  = 3'd1;
    localparam logic [2:0] ST_HDR1  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;
    localparam logic [2:0] ST_CSUM  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs four little-endian bytes into a word and keeps a running XOR checksum.
module loader_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        shift_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_o,
    output logic [7:0]  csum_o
);

    logic [1:0]  cnt_q,  cnt_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  csum_q, csum_d;

    // Bytes shift in from the top so byte k ends up in bits [8k+7:8k].
    always_comb begin
        cnt_d  = cnt_q;
        word_d = word_q;
        csum_d = csum_q;
        if (clear_i) begin
            cnt_d  = '0;
            word_d = '0;
            csum_d = '0;
        end else if (shift_i) begin
            cnt_d  = cnt_q + 2'd1;
            word_d = {byte_i, word_q[31:8]};
            csum_d = csum_q ^ byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            word_q <= '0;
            csum_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            csum_q <= csum_d;
        end
    end

    assign word_o = {byte_i, word_q[31:8]};
    assign last_o = (cnt_q == 2'd3);
    assign csum_o = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (count header, data words, XOR checksum) into
// instruction memory and releases the core only after a good load.
module imem_loader
    import loader_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wd,
    output logic        core_reset,
    output logic        done,
    output logic        error
);

    logic [2:0]       state_q, state_d;
    logic [HDR_W-1:0] n_q, n_d;
    logic [HDR_W-1:0] idx_q, idx_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wd_q, wd_d;
    logic [HDR_W-1:0] n_full;
    logic             xfer, asm_clr, asm_shift, asm_last;
    logic [31:0]      asm_word;
    logic [7:0]       asm_csum;

    assign in_ready = (state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign xfer     = in_valid & in_ready;
    assign n_full   = {in_data, n_q[7:0]};

    loader_word_assembler u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear_i (asm_clr),
        .shift_i (asm_shift),
        .byte_i  (in_data),
        .word_o  (asm_word),
        .last_o  (asm_last),
        .csum_o  (asm_csum)
    );

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        wd_d      = wd_q;
        asm_clr   = 1'b0;
        asm_shift = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR0;
                    n_d     = '0;
                    idx_d   = '0;
                    asm_clr = 1'b1;
                end
            end
            ST_HDR0: if (xfer) begin
                n_d     = {8'h00, in_data};
                state_d = ST_HDR1;
            end
            ST_HDR1: if (xfer) begin
                n_d     = n_full;
                state_d = (n_full == '0 || {16'h0, n_full} > $unsigned(DEPTH_WORDS))
                          ? ST_ERR : ST_DATA;
            end
            ST_DATA: if (xfer) begin
                asm_shift = 1'b1;
                // Latch address/data on the 4th byte so they are valid during WRITE.
                if (asm_last) begin
                    addr_d  = {14'h0, idx_q, 2'b00};
                    wd_d    = asm_word;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                idx_d   = idx_q + 1'b1;
                state_d = (idx_q == n_q - 1'b1) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: if (xfer) begin
                state_d = (in_data == asm_csum) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
        end
    end

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_addr  = addr_q;
    assign imem_wd    = wd_q;
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERR);
    assign core_reset = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good loads, header/checksum errors, stalls, reset abort.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, imem_we, core_reset, done, error;
    logic [31:0] imem_addr, imem_wd;

    int checks = 0;
    int failures = 0;
    int nw = 0;
    int ready_in_write = 0;
    logic [31:0] waddr [0:7];
    logic [31:0] wdat  [0:7];

    imem_loader #(.DEPTH_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            if (nw < 8) begin
                waddr[nw] = imem_addr;
                wdat[nw]  = imem_wd;
            end
            nw = nw + 1;
            if (in_ready) ready_in_write = ready_in_write + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int n;
        n = 0;
        if (stall) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_timeout", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] bytes [], input bit stall);
        foreach (bytes[i]) send_byte(bytes[i], stall);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] fr [];
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        @(negedge clk);
        do_reset();

        check("rst_in_ready",  {31'h0, in_ready},   32'h0);
        check("rst_we",        {31'h0, imem_we},    32'h0);
        check("rst_addr",      imem_addr,           32'h0);
        check("rst_wd",        imem_wd,             32'h0);
        check("rst_core_rst",  {31'h0, core_reset}, 32'h1);
        check("rst_done",      {31'h0, done},       32'h0);
        check("rst_error",     {31'h0, error},      32'h0);

        // Two-word good load.
        nw = 0;
        pulse_start();
        fr = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0};
        send_frame(fr, 1'b0);
        @(negedge clk);
        check("n2_nwrites",   nw, 2);
        check("n2_addr0",     waddr[0], 32'h0);
        check("n2_data0",     wdat[0],  32'h00500013);
        check("n2_addr1",     waddr[1], 32'h4);
        check("n2_data1",     wdat[1],  32'h00100093);
        check("n2_done",      {31'h0, done},       32'h1);
        check("n2_core_rst",  {31'h0, core_reset}, 32'h0);
        check("n2_error",     {31'h0, error},      32'h0);
        check("n2_hold_addr", imem_addr, 32'h4);
        check("n2_hold_wd",   imem_wd,   32'h00100093);

        // Zero word count.
        nw = 0;
        pulse_start();
        fr = '{8'h00, 8'h00};
        send_frame(fr, 1'b0);
        @(negedge clk);
        check("n0_error",    {31'h0, error},      32'h1);
        check("n0_core_rst", {31'h0, core_reset}, 32'h1);
        check("n0_done",     {31'h0, done},       32'h0);
        check("n0_nwrites",  nw, 0);

        // One past capacity.
        nw = 0;
        pulse_start();
        fr = '{8'h41, 8'h00};
        send_frame(fr, 1'b0);
        @(negedge clk);
        check("n65_error",   {31'h0, error}, 32'h1);
        check("n65_nwrites", nw, 0);

        // Exactly at capacity is accepted; start mid-frame is ignored.
        pulse_start();
        fr = '{8'h40, 8'h00, 8'h11};
        send_frame(fr, 1'b0);
        pulse_start();
        check("n64_error", {31'h0, error},    32'h0);
        check("n64_ready", {31'h0, in_ready}, 32'h1);
        do_reset();

        // Bad checksum (good one is 0x08).
        nw = 0;
        pulse_start();
        fr = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
        send_frame(fr, 1'b0);
        @(negedge clk);
        check("bad_cs_nwrites", nw, 1);
        check("bad_cs_data",    wdat[0], 32'h12345678);
        check("bad_cs_error",   {31'h0, error}, 32'h1);
        check("bad_cs_done",    {31'h0, done},  32'h0);

        // Stalled source.
        nw = 0;
        ready_in_write = 0;
        pulse_start();
        fr = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        send_frame(fr, 1'b1);
        @(negedge clk);
        check("stall_nwrites", nw, 1);
        check("stall_addr",    waddr[0], 32'h0);
        check("stall_data",    wdat[0],  32'h12345678);
        check("stall_done",    {31'h0, done}, 32'h1);
        check("stall_ready_we", ready_in_write, 0);

        // Reset mid-frame, then a fresh load.
        pulse_start();
        fr = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        send_frame(fr, 1'b0);
        do_reset();
        check("abort_done",  {31'h0, done},  32'h0);
        check("abort_addr",  imem_addr,      32'h0);
        nw = 0;
        pulse_start();
        fr = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_frame(fr, 1'b0);
        @(negedge clk);
        check("abort_nwrites", nw, 1);
        check("abort_waddr",   waddr[0], 32'h0);
        check("abort_wdata",   wdat[0],  32'hDEADBEEF);
        check("abort_done2",   {31'h0, done}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, instruction memory capacity in 32-bit words.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse that begins a load session.
REQ-005 in_valid  input  1  byte-stream source has a byte.
REQ-006 in_data  input  8  byte-stream payload.
REQ-007 in_ready  output  1  loader accepts in_data this cycle; transfer = in_valid & in_ready.
REQ-008 imem_we  output  1  instruction memory write strobe.
REQ-009 imem_addr  output  32  byte address of the write, always word aligned.
REQ-010 imem_wd  output  32  write data.
REQ-011 core_reset  output  1  holds the core in reset while the program is absent or invalid.
REQ-012 done  output  1  load complete, checksum good.
REQ-013 error  output  1  load aborted: bad header or checksum mismatch.

Function
REQ-014 The FSM SHALL have states IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR.
REQ-015 Frame format: HDR0 = word count N low byte, HDR1 = N high byte, then 4N data bytes little-endian per word, then one checksum byte.
REQ-016 start in IDLE, DONE or ERR SHALL go to HDR0 next cycle and clear word index, byte count, checksum; start in any other state is ignored.
REQ-017 in_ready SHALL be 1 exactly in HDR0, HDR1, DATA, CSUM; 0 elsewhere.
REQ-018 After the HDR1 transfer, N = 0 or N > DEPTH_WORDS SHALL go to ERR, otherwise DATA.
REQ-019 In DATA, transfer k (k = 0..3) SHALL place in_data at word bits [8k+7:8k]; the 4th transfer goes to WRITE.
REQ-020 WRITE SHALL last one cycle with imem_we = 1, imem_addr = 4*word_idx, imem_wd = assembled word; then word_idx increments and the FSM goes to CSUM if word_idx was N-1, else DATA.
REQ-021 imem_we SHALL be 0 in every state but WRITE; throughput is 4 bytes per 5 cycles at minimum.
REQ-022 Running checksum SHALL be XOR of all data bytes (header excluded).
REQ-023 CSUM transfer matching the checksum SHALL go to DONE, mismatch to ERR.
REQ-024 done = 1 only in DONE; error = 1 only in ERR; core_reset = 0 only in DONE.
REQ-025 Source stalls (in_valid = 0) SHALL hold all state; no timeout.
REQ-026 imem_addr and imem_wd SHALL hold their last values outside WRITE.

Reset
REQ-027 reset SHALL force IDLE, in_ready = 0, imem_we = 0, imem_addr = 0, imem_wd = 0, core_reset = 1, done = 0, error = 0, all counters and checksum 0.
REQ-028 reset SHALL take priority over start and over an in-flight transfer, including mid-WRITE; the write in that cycle still occurs, no later write does.

Structure
REQ-029 Shared package loader_pkg SHALL hold the state enumeration, DEPTH_WORDS default, and header width (16).
REQ-030 One sub-module, loader_word_assembler (byte counter, shift-in, XOR checksum), is natural; FSM and address counter stay in imem_loader.

Verification
REQ-031 N = 2, bytes 13 00 50 00 | 93 00 10 00 | checksum 0xC0 -> writes addr 0x0 data 0x00500013, addr 0x4 data 0x00100093, then done = 1, core_reset = 0.
REQ-032 N = 0 (header 00 00) -> error = 1, core_reset = 1, no imem_we pulse.
REQ-033 N = 65 with DEPTH_WORDS = 64 -> ERR after HDR1, no writes.
REQ-034 Valid N = 1 frame with checksum off by one -> one write occurs, then error = 1, done = 0.
REQ-035 in_valid toggled 1/0 every cycle through a N = 1 frame -> same write and DONE as an unstalled run, in_ready 0 during WRITE.
REQ-036 reset asserted after 2 data bytes, then start and a full N = 1 frame -> only the new word written at addr 0x0, done = 1.
